// File: rtl/snn_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : snn_pkg
//  Description : Shared constants and controller state type for the SNN
//                inference path (frame controller and snn_core).
//  Revision    : 1.0 - initial release
// ============================================================================
package snn_pkg;

    localparam int NUM_INPUTS   = 784;
    localparam int NUM_BYTES    = 98;
    localparam int INPUT_ADDR_W = 10;

    typedef enum logic [2:0] {
        LOAD   = 3'd0,
        UNPACK = 3'd1,
        KICK   = 3'd2,
        RUN    = 3'd3,
        SEND   = 3'd4,
        TXW    = 3'd5
    } ctrl_state_t;

endpackage
`default_nettype wire

// File: rtl/snn_frame_ctrl_if.sv
`default_nettype none
// ============================================================================
//  Module      : snn_frame_ctrl_if
//  Description : Bundle of UART, input-RAM, snn_core and status signals seen
//                by the frame controller. master = controller side.
//  Revision    : 1.0 - initial release
// ============================================================================
interface snn_frame_ctrl_if;
    import snn_pkg::*;

    logic                    rx_rdy;
    logic [7:0]              rx_data;
    logic                    ram_we;
    logic                    ram_d;
    logic [INPUT_ADDR_W-1:0] ram_addr;
    logic [INPUT_ADDR_W-1:0] snn_addr;
    logic                    snn_start;
    logic                    snn_done;
    logic [3:0]              snn_digit;
    logic                    tx_start;
    logic [7:0]              tx_data;
    logic                    tx_done;
    logic [7:0]              led;
    logic                    busy;
    logic                    overrun;

    modport master (
        input  rx_rdy, rx_data, snn_addr, snn_done, snn_digit, tx_done,
        output ram_we, ram_d, ram_addr, snn_start, tx_start, tx_data, led,
               busy, overrun
    );

    modport slave (
        output rx_rdy, rx_data, snn_addr, snn_done, snn_digit, tx_done,
        input  ram_we, ram_d, ram_addr, snn_start, tx_start, tx_data, led,
               busy, overrun
    );

endinterface
`default_nettype wire

// File: rtl/snn_byte_unpack.sv
`default_nettype none
// ============================================================================
//  Module      : snn_byte_unpack
//  Description : Byte-to-bit serialiser. Loads one byte, then presents it
//                LSB first, one bit per shift, flagging the eighth bit.
//  Revision    : 1.0 - initial release
// ============================================================================
module snn_byte_unpack (
    input  wire logic       clk,
    input  wire logic       rst,
    input  wire logic       i_load,
    input  wire logic [7:0] i_data,
    input  wire logic       i_shift,
    output logic            o_bit,
    output logic            o_last_bit
);

    logic [7:0] r_shift;
    logic [2:0] r_bit_cnt;

    // Load a fresh byte or shift the current one right by one bit
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_shift   <= 8'h00;
            r_bit_cnt <= 3'd0;
        end else if (i_load) begin
            r_shift   <= i_data;
            r_bit_cnt <= 3'd0;
        end else if (i_shift) begin
            r_shift   <= {1'b0, r_shift[7:1]};
            r_bit_cnt <= r_bit_cnt + 3'd1;
        end
    end

    assign o_bit      = r_shift[0];
    assign o_last_bit = (r_bit_cnt == 3'd7);

endmodule
`default_nettype wire

// File: rtl/snn_frame_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : snn_frame_ctrl
//  Description : Sequencer for one SNN inference: unpacks a UART-delivered
//                bitmap into the input RAM, kicks snn_core, captures the
//                resulting digit and returns it over UART TX.
//  Revision    : 1.0 - initial release
// ============================================================================
module snn_frame_ctrl #(
    parameter int NUM_BYTES = snn_pkg::NUM_BYTES,
    parameter int ADDR_W    = snn_pkg::INPUT_ADDR_W
) (
    input  wire logic          clk,
    input  wire logic          rst,
    snn_frame_ctrl_if.master   if_bus
);
    import snn_pkg::*;

    localparam int                BYTE_W      = $clog2(NUM_BYTES + 1);
    localparam logic [ADDR_W-1:0] c_last_addr = ADDR_W'(NUM_BYTES * 8 - 1);
    localparam logic [BYTE_W-1:0] c_last_byte = BYTE_W'(NUM_BYTES - 1);

    ctrl_state_t       r_state;
    logic [BYTE_W-1:0] r_byte_cnt;
    logic [ADDR_W-1:0] r_wr_addr;
    logic [3:0]        r_digit;
    logic              r_overrun;

    logic w_load;
    logic w_shift;
    logic w_bit;
    logic w_last_bit;
    logic w_own_ram;

    assign w_load    = (r_state == LOAD) && if_bus.rx_rdy;
    assign w_shift   = (r_state == UNPACK);
    assign w_own_ram = (r_state == LOAD) || (r_state == UNPACK);

    snn_byte_unpack u_unpack (
        .clk        (clk),
        .rst        (rst),
        .i_load     (w_load),
        .i_data     (if_bus.rx_data),
        .i_shift    (w_shift),
        .o_bit      (w_bit),
        .o_last_bit (w_last_bit)
    );

    // Frame sequencing: byte intake, bit unpacking, core run and result send
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= LOAD;
            r_byte_cnt <= '0;
            r_wr_addr  <= '0;
        end else begin
            case (r_state)
                LOAD: begin
                    if (if_bus.rx_rdy) r_state <= UNPACK;
                end
                UNPACK: begin
                    // Address saturates at the final pixel so it never wraps
                    if (r_wr_addr != c_last_addr) r_wr_addr <= r_wr_addr + 1'b1;
                    if (w_last_bit) begin
                        r_byte_cnt <= r_byte_cnt + 1'b1;
                        r_state    <= (r_byte_cnt == c_last_byte) ? KICK : LOAD;
                    end
                end
                KICK: r_state <= RUN;
                RUN: begin
                    if (if_bus.snn_done) r_state <= SEND;
                end
                SEND: r_state <= TXW;
                TXW: begin
                    if (if_bus.tx_done) begin
                        r_byte_cnt <= '0;
                        r_wr_addr  <= '0;
                        r_state    <= LOAD;
                    end
                end
                default: r_state <= LOAD;
            endcase
        end
    end

    // Capture the classified digit; it persists until the next result
    always_ff @(posedge clk or posedge rst) begin
        if (rst)                                      r_digit <= 4'h0;
        else if ((r_state == RUN) && if_bus.snn_done) r_digit <= if_bus.snn_digit;
    end

    // Sticky flag for bytes that arrive while the controller cannot take them
    always_ff @(posedge clk or posedge rst) begin
        if (rst)                                         r_overrun <= 1'b0;
        else if (if_bus.rx_rdy && (r_state != LOAD))     r_overrun <= 1'b1;
    end

    assign if_bus.ram_we    = (r_state == UNPACK);
    assign if_bus.ram_d     = w_bit;
    assign if_bus.ram_addr  = w_own_ram ? r_wr_addr : if_bus.snn_addr;
    assign if_bus.snn_start = (r_state == KICK);
    assign if_bus.tx_start  = (r_state == SEND);
    assign if_bus.tx_data   = {4'h0, r_digit};
    assign if_bus.led       = {4'h0, r_digit};
    assign if_bus.busy      = !((r_state == LOAD) && (r_byte_cnt == '0));
    assign if_bus.overrun   = r_overrun;

endmodule
`default_nettype wire

// File: tb/tb_snn_frame_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_snn_frame_ctrl
//  Description : Directed self-checking bench for snn_frame_ctrl.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_snn_frame_ctrl;

    localparam int NB   = 98;
    localparam int NPIX = 784;

    logic clk = 1'b0;
    logic rst = 1'b1;

    snn_frame_ctrl_if bus ();

    snn_frame_ctrl dut (
        .clk    (clk),
        .rst    (rst),
        .if_bus (bus)
    );

    always #5 clk = ~clk;

    int n_pass = 0;
    int n_chk  = 0;

    // Observation of the RAM port, start and tx pulses
    logic       ram_m [0:NPIX-1];
    int         we_cnt = 0, start_cnt = 0, tx_cnt = 0, cyc = 0;
    int         last_we_cyc = 0, start_cyc = 0;
    logic [9:0] last_we_addr = '0, first_addr = '1;
    logic       first_pend = 1'b1;

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (rst) first_pend <= 1'b1;
        if (bus.ram_we) begin
            we_cnt       <= we_cnt + 1;
            last_we_cyc  <= cyc;
            last_we_addr <= bus.ram_addr;
            if (int'(bus.ram_addr) < NPIX) ram_m[bus.ram_addr] <= bus.ram_d;
            if (first_pend && !rst) begin
                first_addr <= bus.ram_addr;
                first_pend <= 1'b0;
            end
        end
        if (bus.snn_start) begin
            start_cnt <= start_cnt + 1;
            start_cyc <= cyc;
        end
        if (bus.tx_start) tx_cnt <= tx_cnt + 1;
    end

    function automatic int count_bad(input logic [7:0] p);
        int bad = 0;
        for (int a = 0; a < NPIX; a++) if (ram_m[a] !== p[a % 8]) bad++;
        return bad;
    endfunction

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic send_byte(input logic [7:0] b);
        @(negedge clk); bus.rx_rdy = 1'b1; bus.rx_data = b;
        @(negedge clk); bus.rx_rdy = 1'b0; bus.rx_data = 8'h00;
    endtask

    task automatic send_bytes(input logic [7:0] b, input int n);
        for (int i = 0; i < n; i++) begin
            send_byte(b);
            idle(18);
        end
    endtask

    task automatic pulse_done(input logic [3:0] d);
        @(negedge clk); bus.snn_done = 1'b1; bus.snn_digit = d;
        @(negedge clk); bus.snn_done = 1'b0; bus.snn_digit = 4'hF;
    endtask

    task automatic pulse_tx_done();
        @(negedge clk); bus.tx_done = 1'b1;
        @(negedge clk); bus.tx_done = 1'b0;
    endtask

    task automatic test_reset();
        logic [31:0] v;
        idle(2);
        v = {bus.ram_we, bus.ram_d, bus.ram_addr, bus.snn_start, bus.tx_start,
             bus.tx_data, bus.led, bus.busy, bus.overrun};
        n_chk++; if (v !== 32'h0) $display("FAIL reset_outputs: got %h expected 0", v); else n_pass++;
        rst = 1'b0;
        idle(2);
        n_chk++; if (bus.busy !== 1'b0) $display("FAIL idle_busy: got %b expected 0", bus.busy); else n_pass++;
    endtask

    task automatic test_frame();
        int we0, st0, bad;
        we0 = we_cnt; st0 = start_cnt;
        send_bytes(8'hA5, NB);
        n_chk++; if (we_cnt - we0 !== NPIX) $display("FAIL frame_writes: got %0d expected %0d", we_cnt - we0, NPIX); else n_pass++;
        n_chk++; if (start_cnt - st0 !== 1) $display("FAIL frame_starts: got %0d expected 1", start_cnt - st0); else n_pass++;
        n_chk++; if (start_cyc !== last_we_cyc + 1) $display("FAIL start_timing: got cycle %0d expected %0d", start_cyc, last_we_cyc + 1); else n_pass++;
        n_chk++; if (last_we_addr !== 10'd783) $display("FAIL last_addr: got %0d expected 783", last_we_addr); else n_pass++;
        bad = count_bad(8'hA5);
        n_chk++; if (bad !== 0) $display("FAIL ram_pattern_a5: got %0d bad bits expected 0", bad); else n_pass++;
        n_chk++; if (bus.busy !== 1'b1) $display("FAIL run_busy: got %b expected 1", bus.busy); else n_pass++;
    endtask

    task automatic test_spurious_tx_done_in_run();
        int tx0;
        tx0 = tx_cnt;
        pulse_tx_done();
        idle(2);
        n_chk++; if (tx_cnt !== tx0) $display("FAIL run_txdone_txstart: got %0d expected %0d", tx_cnt, tx0); else n_pass++;
        n_chk++; if (bus.busy !== 1'b1) $display("FAIL run_txdone_busy: got %b expected 1", bus.busy); else n_pass++;
    endtask

    task automatic test_addr_mux_run();
        @(negedge clk); bus.snn_addr = 10'h155; #1;
        n_chk++; if ({bus.ram_we, bus.ram_addr} !== {1'b0, 10'h155}) $display("FAIL mux_run_155: got we=%b addr=%h expected we=0 addr=155", bus.ram_we, bus.ram_addr); else n_pass++;
        bus.snn_addr = 10'h2AA; #1;
        n_chk++; if (bus.ram_addr !== 10'h2AA) $display("FAIL mux_run_2aa: got %h expected 2aa", bus.ram_addr); else n_pass++;
        bus.snn_addr = 10'h155;
    endtask

    task automatic test_result();
        pulse_done(4'd7);
        n_chk++; if (bus.tx_start !== 1'b1) $display("FAIL tx_start_pulse: got %b expected 1", bus.tx_start); else n_pass++;
        n_chk++; if (bus.tx_data !== 8'h07) $display("FAIL tx_data: got %h expected 07", bus.tx_data); else n_pass++;
        n_chk++; if (bus.led !== 8'h07) $display("FAIL led: got %h expected 07", bus.led); else n_pass++;
        @(negedge clk);
        n_chk++; if (bus.tx_start !== 1'b0) $display("FAIL tx_start_width: got %b expected 0", bus.tx_start); else n_pass++;
        idle(3);
        n_chk++; if (bus.busy !== 1'b1) $display("FAIL txw_busy: got %b expected 1", bus.busy); else n_pass++;
        pulse_tx_done();
        n_chk++; if ({bus.busy, bus.ram_addr} !== {1'b0, 10'h000}) $display("FAIL back_to_load: got busy=%b addr=%h expected busy=0 addr=000", bus.busy, bus.ram_addr); else n_pass++;
    endtask

    task automatic test_spurious_done_in_load();
        int tx0;
        tx0 = tx_cnt;
        pulse_done(4'd9);
        idle(2);
        n_chk++; if (bus.led !== 8'h07) $display("FAIL load_done_led: got %h expected 07", bus.led); else n_pass++;
        n_chk++; if (tx_cnt !== tx0) $display("FAIL load_done_txstart: got %0d expected %0d", tx_cnt, tx0); else n_pass++;
        n_chk++; if (bus.busy !== 1'b0) $display("FAIL load_done_busy: got %b expected 0", bus.busy); else n_pass++;
    endtask

    task automatic test_overrun();
        int we0, st0, tx0, bad;
        we0 = we_cnt; st0 = start_cnt;
        n_chk++; if (bus.overrun !== 1'b0) $display("FAIL overrun_initial: got %b expected 0", bus.overrun); else n_pass++;
        send_bytes(8'hA5, 5);
        // junk mid-UNPACK
        send_byte(8'hA5); idle(2); send_byte(8'hFF); idle(15);
        n_chk++; if (bus.overrun !== 1'b1) $display("FAIL overrun_unpack: got %b expected 1", bus.overrun); else n_pass++;
        // junk on the very cycle UNPACK returns to LOAD
        send_byte(8'hA5); idle(6); send_byte(8'hFF); idle(11);
        send_bytes(8'hA5, NB - 7);
        tx0 = tx_cnt;
        send_byte(8'hFF); idle(3);
        n_chk++; if (bus.overrun !== 1'b1) $display("FAIL overrun_run: got %b expected 1", bus.overrun); else n_pass++;
        n_chk++; if (tx_cnt !== tx0) $display("FAIL overrun_run_tx: got %0d expected %0d", tx_cnt, tx0); else n_pass++;
        n_chk++; if (we_cnt - we0 !== NPIX) $display("FAIL overrun_writes: got %0d expected %0d", we_cnt - we0, NPIX); else n_pass++;
        n_chk++; if (start_cnt - st0 !== 1) $display("FAIL overrun_starts: got %0d expected 1", start_cnt - st0); else n_pass++;
        bad = count_bad(8'hA5);
        n_chk++; if (bad !== 0) $display("FAIL overrun_pattern: got %0d bad bits expected 0", bad); else n_pass++;
        pulse_done(4'd3);
        idle(2);
        pulse_tx_done();
        n_chk++; if ({bus.led, bus.overrun, bus.busy} !== {8'h03, 1'b1, 1'b0}) $display("FAIL overrun_end: got led=%h ovr=%b busy=%b expected led=03 ovr=1 busy=0", bus.led, bus.overrun, bus.busy); else n_pass++;
    endtask

    task automatic test_reset_midframe();
        logic [31:0] v;
        int we0, st0, bad;
        send_bytes(8'h3C, 40);
        @(negedge clk); rst = 1'b1; #1;
        v = {bus.ram_we, bus.ram_d, bus.ram_addr, bus.snn_start, bus.tx_start,
             bus.tx_data, bus.led, bus.busy, bus.overrun};
        n_chk++; if (v !== 32'h0) $display("FAIL midframe_reset_outputs: got %h expected 0", v); else n_pass++;
        @(negedge clk); rst = 1'b0;
        idle(2);
        we0 = we_cnt; st0 = start_cnt;
        send_byte(8'h3C);
        for (int j = 0; j < 8; j++) begin
            n_chk++;
            if ({bus.ram_we, bus.ram_addr, bus.ram_d} !== {1'b1, 10'(j), 1'(8'h3C >> j)})
                $display("FAIL unpack_follow_%0d: got we=%b addr=%0d d=%b expected we=1 addr=%0d d=%b",
                         j, bus.ram_we, bus.ram_addr, bus.ram_d, j, 1'(8'h3C >> j));
            else n_pass++;
            @(negedge clk);
        end
        idle(10);
        send_bytes(8'h3C, NB - 1);
        n_chk++; if (first_addr !== 10'd0) $display("FAIL restart_addr: got %0d expected 0", first_addr); else n_pass++;
        n_chk++; if (we_cnt - we0 !== NPIX) $display("FAIL fresh_writes: got %0d expected %0d", we_cnt - we0, NPIX); else n_pass++;
        n_chk++; if (start_cnt - st0 !== 1) $display("FAIL fresh_starts: got %0d expected 1", start_cnt - st0); else n_pass++;
        bad = count_bad(8'h3C);
        n_chk++; if (bad !== 0) $display("FAIL fresh_pattern: got %0d bad bits expected 0", bad); else n_pass++;
    endtask

    initial begin
        bus.rx_rdy    = 1'b0;
        bus.rx_data   = 8'h00;
        bus.snn_addr  = 10'h155;
        bus.snn_done  = 1'b0;
        bus.snn_digit = 4'h0;
        bus.tx_done   = 1'b0;
        test_reset();
        test_frame();
        test_spurious_tx_done_in_run();
        test_addr_mux_run();
        test_result();
        test_spurious_done_in_load();
        test_overrun();
        test_reset_midframe();
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
`default_nettype wire
